// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register-busy scoreboard with load-use stall detection,
// taken-branch flush window and optional stall/flush performance counters.
// Optional feature macro: HAZARD_SCOREBOARD_PERF_EN (defined -> perf counters
// exist; undefined -> stall_cycles/flush_cycles tied to zero).
module hazard_scoreboard #(
   parameter int ADDR_WIDTH = 5,
   parameter int LAT_WIDTH  = 2,
   parameter int BR_PENALTY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [ADDR_WIDTH-1:0] regS_addr_id,
   input  logic [ADDR_WIDTH-1:0] regT_addr_id,
   input  logic                  regS_used_id,
   input  logic                  regT_used_id,
   input  logic                  id_wr_en,
   input  logic [ADDR_WIDTH-1:0] id_wr_addr,
   input  logic [LAT_WIDTH-1:0]  id_wr_lat,
   input  logic                  branch,
   output logic                  clear_ctrl,
   output logic                  hold_if,
   output logic                  hold_pc,
   output logic                  if_flush,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_cycles
);

   localparam int unsigned NREG = 1 << ADDR_WIDTH;
   localparam logic [2:0]  FLUSH_RELOAD = 3'(BR_PENALTY - 1);

   logic [LAT_WIDTH-1:0] cnt_q [NREG];
   logic [LAT_WIDTH-1:0] cnt_d [NREG];
   logic [2:0]           fcnt_q, fcnt_d;

   logic hazard_s, hazard_t;
   logic flush_active;
   logic stall;
   logic issue;
   logic load_en;

   // Hazard detection and control decode, all combinational in the ID cycle
   always_comb begin
      hazard_s     = regS_used_id && (regS_addr_id != '0) && (cnt_q[regS_addr_id] != '0);
      hazard_t     = regT_used_id && (regT_addr_id != '0) && (cnt_q[regT_addr_id] != '0);
      flush_active = (fcnt_q != '0);
      stall        = id_valid && !branch && !flush_active && (hazard_s || hazard_t);
      issue        = id_valid && !stall && !branch && !flush_active;
      load_en      = issue && id_wr_en && (id_wr_addr != '0) && (id_wr_lat != '0);
   end

   assign hold_if    = stall;
   assign hold_pc    = stall;
   assign if_flush   = branch || flush_active;
   assign clear_ctrl = stall || branch || flush_active;

   // Next busy counts: newest write reloads its entry, all others count down to zero
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (load_en && (id_wr_addr == ADDR_WIDTH'(r))) begin
            cnt_d[r] = id_wr_lat;
         end else if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - LAT_WIDTH'(1);
         end else begin
            cnt_d[r] = cnt_q[r];
         end
      end
   end

   // Next flush window count: any branch restarts the window
   always_comb begin
      if (branch) begin
         fcnt_d = FLUSH_RELOAD;
      end else if (fcnt_q != '0) begin
         fcnt_d = fcnt_q - 3'd1;
      end else begin
         fcnt_d = fcnt_q;
      end
   end

   // Scoreboard and flush window state
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '{default: '0};
         fcnt_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         fcnt_q <= fcnt_d;
      end
   end

`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters for stall and flush cycles
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (if_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_cycles = flush_cnt_q;
`else
   assign stall_cycles = '0;
   assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random stimulus, reference model based on
// per-register "ready cycle" and "flush window end cycle" bookkeeping.
module tb_hazard_scoreboard;

   localparam int AW   = 5;
   localparam int LW   = 2;
   localparam int BRP  = 2;
   localparam int NREG = 1 << AW;

   logic          clk;
   logic          rst;
   logic          id_valid;
   logic [AW-1:0] regS_addr_id, regT_addr_id;
   logic          regS_used_id, regT_used_id;
   logic          id_wr_en;
   logic [AW-1:0] id_wr_addr;
   logic [LW-1:0] id_wr_lat;
   logic          branch;
   logic          clear_ctrl, hold_if, hold_pc, if_flush;
   logic [31:0]   stall_cycles, flush_cycles;

   hazard_scoreboard #(
      .ADDR_WIDTH (AW),
      .LAT_WIDTH  (LW),
      .BR_PENALTY (BRP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .regS_addr_id (regS_addr_id),
      .regT_addr_id (regT_addr_id),
      .regS_used_id (regS_used_id),
      .regT_used_id (regT_used_id),
      .id_wr_en     (id_wr_en),
      .id_wr_addr   (id_wr_addr),
      .id_wr_lat    (id_wr_lat),
      .branch       (branch),
      .clear_ctrl   (clear_ctrl),
      .hold_if      (hold_if),
      .hold_pc      (hold_pc),
      .if_flush     (if_flush),
      .stall_cycles (stall_cycles),
      .flush_cycles (flush_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          stall;
      bit          flush;
      bit          clr;
      logic [31:0] sc;
      logic [31:0] fc;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: a register is busy while the current cycle is before
   // its ready cycle; the flush window is open up to flush_end inclusive.
   int ready [NREG];
   int flush_end;
   int cyc;
   int m_sc, m_fc;

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, req);
      end
   endtask

   // Monitor: every cycle the DUT presents a control word; compare against the queue
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("hold_if",      e.cyc, 32'(hold_if),    32'(e.stall));
         chk("hold_pc",      e.cyc, 32'(hold_pc),    32'(e.stall));
         chk("clear_ctrl",   e.cyc, 32'(clear_ctrl), 32'(e.clr));
         chk("if_flush",     e.cyc, 32'(if_flush),   32'(e.flush));
         chk("stall_cycles", e.cyc, stall_cycles,    e.sc);
         chk("flush_cycles", e.cyc, flush_cycles,    e.fc);
      end
   end

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) ready[i] = 0;
      flush_end = -1;
      m_sc = 0;
      m_fc = 0;
   endtask

   task automatic step(input bit v, input int s, input bit su, input int t, input bit tu,
                       input bit we, input int wa, input int wl, input bit br, input bit r);
      bit   hs, ht, fa, st, fl, iss;
      exp_t e;
      id_valid     = v;
      regS_addr_id = AW'(s);
      regS_used_id = su;
      regT_addr_id = AW'(t);
      regT_used_id = tu;
      id_wr_en     = we;
      id_wr_addr   = AW'(wa);
      id_wr_lat    = LW'(wl);
      branch       = br;
      rst          = r;
      hs  = su && (s != 0) && (cyc < ready[s]);
      ht  = tu && (t != 0) && (cyc < ready[t]);
      fa  = (cyc <= flush_end);
      st  = v && !br && !fa && (hs || ht);
      fl  = br || fa;
      iss = v && !st && !br && !fa;
      e.stall = st;
      e.flush = fl;
      e.clr   = st || fl;
`ifdef HAZARD_SCOREBOARD_PERF_EN
      e.sc = 32'(m_sc);
      e.fc = 32'(m_fc);
`else
      e.sc = '0;
      e.fc = '0;
`endif
      e.cyc = cyc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (r) begin
         model_reset();
      end else begin
         if (iss && we && (wa != 0) && (wl != 0)) ready[wa] = cyc + wl + 1;
         if (br) flush_end = cyc + BRP - 1;
         m_sc += int'(st);
         m_fc += int'(fl);
      end
      cyc++;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int a, input int l);
      step(1, 0, 0, 0, 0, 1, a, l, 0, 0);
   endtask

   task automatic use_s(input int a, input bit br);
      step(1, a, 1, 0, 0, 0, 0, 0, br, 0);
   endtask

   initial begin
      cyc = 0;
      model_reset();
      rst = 1'b1;
      id_valid = 0; regS_addr_id = '0; regT_addr_id = '0;
      regS_used_id = 0; regT_used_id = 0; id_wr_en = 0;
      id_wr_addr = '0; id_wr_lat = '0; branch = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // outputs idle after reset
      idle();
      idle();
      // load-use: one stall, then proceeds
      wr(5, 1);
      use_s(5, 0);
      use_s(5, 0);
      idle();
      // long latency on r7, independent r8
      wr(7, 3);
      repeat (4) use_s(7, 0);
      wr(7, 3);
      use_s(8, 0);
      repeat (3) idle();
      // r0 and unused operands
      wr(0, 3);
      use_s(0, 0);
      step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      wr(7, 3);
      step(1, 0, 0, 7, 0, 0, 0, 0, 0, 0);
      repeat (3) idle();
      // branch over a pending hazard, second branch extends the window
      wr(7, 3);
      use_s(7, 1);
      use_s(7, 1);
      use_s(7, 0);
      use_s(7, 0);
      use_s(7, 0);
      repeat (3) idle();
      // WAW: newest write wins
      wr(4, 3);
      wr(4, 1);
      use_s(4, 0);
      use_s(4, 0);
      idle();
      // reset with a pending hazard and open flush window
      wr(9, 3);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 9, 1, 0, 0, 0, 0, 0, 0, 1);
      use_s(9, 0);
      idle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(3) != 0,
              int'($urandom_range(15)), $urandom_range(1) == 1,
              int'($urandom_range(15)), $urandom_range(1) == 1,
              $urandom_range(1) == 1, int'($urandom_range(15)), int'($urandom_range(3)),
              $urandom_range(15) == 0, $urandom_range(199) == 0);
      end
      idle();

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
